instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
//  Boot loader between the UART RX byte stream and the instruction memory write port.
//  Takes a length-prefixed program from the UART and packs it big-endian into 32-bit words.
//  Drives wr_data/wr_addr/wr_en, which connect to instruction memory data_in/dir/we.
//  Holds the processor out of run (cpu_run=0) until the complete program is written.
// PARAMETERS
//  DATA_WIDTH      32       instruction word width; 4 bytes per word
//  BYTE_WIDTH      8        UART byte width and write-address width
//  MAX_WORDS       64       largest legal length byte (256-byte memory / 4)
//  TIMEOUT_CYCLES  100000   idle clocks allowed between bytes while loading
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous reset, active low
//  start      in   1           1-cycle pulse: arm the loader (honoured only in IDLE/DONE/ERR)
//  byte_in    in   BYTE_WIDTH  UART RX byte
//  byte_valid in   1           byte_in valid for this cycle; cannot be stalled
//  wr_data    out  DATA_WIDTH  assembled word (first received byte in [31:24])
//  wr_addr    out  BYTE_WIDTH  byte address of wr_data; 0,4,8,...
//  wr_en      out  1           1-cycle write strobe to instruction memory
//  busy       out  1           1 in LEN or COLLECT
//  done       out  1           1 in DONE
//  err        out  1           1 in ERR
//  cpu_run    out  1           1 in DONE only; releases the processor
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output, shift reg, counters = 0.
//  States IDLE -> LEN -> COLLECT -> DONE; LEN/COLLECT -> ERR.
//   IDLE/DONE/ERR: on start go to LEN; clear addr, word count, byte index, timer, done, err.
//     byte_valid is ignored in these states. start in LEN/COLLECT is ignored.
//   LEN: first accepted byte is N.
//     1<=N<=MAX_WORDS: go to COLLECT.
//     N=0 or N>MAX_WORDS: go to ERR; no writes.
//   COLLECT: each accepted byte does shreg <= {shreg[23:0],byte_in}; byte index increments mod 4.
//     On the 4th byte, the cycle after acceptance has:
//       wr_en=1 for exactly 1 cycle; wr_data = the packed word; wr_addr = current address.
//     Address advances by 4 after each write. A byte accepted during a wr_en cycle is
//     the first byte of the next word; no byte is ever dropped.
//     After the Nth write, the next cycle enters DONE (done=1, cpu_run=1).
//  Latency: 4th byte accepted at cycle t -> wr_en at t+1.
//     Last write at t+1 -> done and cpu_run at t+2.
//  Sustained input: one byte per cycle is supported.
//  Timeout: timer clears on every accepted byte and counts otherwise in LEN/COLLECT.
//     When it reaches TIMEOUT_CYCLES-1: go to ERR.
//     A partial word is discarded; completed writes are not undone; cpu_run stays 0.
//  Address range: max address = 4*(MAX_WORDS-1) = 0xFC; the length check prevents wrap.
//  Reset mid-load: immediate return to IDLE with all outputs 0.
//     Memory contents are left as written.
//  Outputs are registered; no combinational input-to-output paths.
// TESTING
//  T1 start; bytes 02 DE AD BE EF 00 00 00 13
//     -> write (0x00, 0xDEADBEEF), then (0x04, 0x00000013); done=cpu_run=1 two cycles after last byte.
//  T2 start; length 00; separately length 0x41 -> err=1, no wr_en, cpu_run=0.
//  T3 64-word load, one byte per cycle
//     -> 64 wr_en pulses; last wr_addr = 0xFC; no byte lost; done=1.
//  T4 start; 01 AA BB; then idle TIMEOUT_CYCLES clocks -> err=1, no wr_en.
//     A later start plus a valid stream loads correctly.
//  T5 rst_n low during the 2nd word of a 3-word load -> all outputs 0 at once.
//     A following start reloads from addr 0.
//  T6 start pulsed during COLLECT; bytes sent in IDLE
//     -> both ignored; write sequence unchanged.

Source files
------------

// File: rtl/instr_loader.sv
// Boot loader: takes a length-prefixed byte stream from the UART, packs it big-endian
// into instruction words and writes them to instruction memory, then releases the CPU.
module instr_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned MAX_WORDS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [BYTE_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_run
);

    localparam int unsigned BPW  = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDXW = (BPW > 2) ? $clog2(BPW) : 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(BPW - 1);
    localparam logic [BYTE_WIDTH-1:0] MAXW      = BYTE_WIDTH'(MAX_WORDS);
    localparam logic [BYTE_WIDTH-1:0] ADDR_STEP = BYTE_WIDTH'(BPW);
    localparam logic [TW-1:0]         TMAX      = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_COLLECT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [BYTE_WIDTH-1:0]   cnt_q, cnt_d;
    logic [BYTE_WIDTH-1:0]   len_q, len_d;
    logic [BYTE_WIDTH-1:0]   addr_q, addr_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [BYTE_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   shifted;

    assign shifted = {shreg_q[DATA_WIDTH-BYTE_WIDTH-1:0], byte_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            timer_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    shreg_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    timer_d = '0;
                end
            end
            S_LEN: begin
                if (byte_valid) begin
                    timer_d = '0;
                    if (byte_in == '0 || byte_in > MAXW) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = byte_in;
                        state_d = S_COLLECT;
                    end
                end else if (timer_q == TMAX) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COLLECT: begin
                // cnt_q reaches len_q in the cycle the final word is strobed out
                if (cnt_q == len_q) begin
                    state_d = S_DONE;
                end else if (byte_valid) begin
                    timer_d = '0;
                    shreg_d = shifted;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = shifted;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + ADDR_STEP;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign busy    = (state_q == S_LEN) || (state_q == S_COLLECT);
    assign done    = (state_q == S_DONE);
    assign err     = (state_q == S_ERR);
    assign cpu_run = (state_q == S_DONE);

endmodule
